// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Brief    : Shared widths, types and requant helper for the 1x1 conv output path.
// Revision : 1.0
// ============================================================================
package conv_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_ACC_W = 40;
  localparam int DEF_OUT_W = 16;
  localparam int ACC_MAX_W = 64;

  typedef logic signed [ACC_MAX_W-1:0] acc_t;
  typedef logic signed [DEF_OUT_W-1:0] out_t;

  // Result is returned at full accumulator width, already clamped to out_w bits,
  // so callers with a non-default output width can simply slice it.
  function automatic acc_t round_shift_sat(input acc_t acc, input int unsigned shift,
                                           input bit relu,
                                           input int unsigned out_w = DEF_OUT_W);
    acc_t r;
    acc_t lim;
    r   = (acc + (acc_t'(1) <<< (shift - 1))) >>> shift;
    lim = acc_t'(1) <<< (out_w - 1);
    if (relu && (r < 0)) r = '0;
    if (r > (lim - 1))   r = lim - 1;
    else if (r < -lim)   r = -lim;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv1x1_accum_requant_if.sv
`default_nettype none
// ============================================================================
// Module   : conv1x1_accum_requant_if
// Brief    : MAC-result input beats and ready/valid pixel output of the requant block.
// Revision : 1.0
// ============================================================================
interface conv1x1_accum_requant_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
);
  logic             valid_in;
  logic [IN_W-1:0]  y_in;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             almost_full;
  logic             overflow;

  modport slave (
    input  valid_in, y_in, out_ready,
    output out_valid, out_data, almost_full, overflow
  );

  modport master (
    output valid_in, y_in, out_ready,
    input  out_valid, out_data, almost_full, overflow
  );
endinterface
`default_nettype wire

// File: rtl/conv_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : conv_out_fifo
// Brief    : Synchronous FIFO with separate occupancy count; push and pop may coincide when full.
// Revision : 1.0
// ============================================================================
module conv_out_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  wire logic                       clk,
  input  wire logic                       rst_n,
  input  wire logic                       push,
  input  wire logic [DATA_W-1:0]          din,
  input  wire logic                       pop,
  output logic      [DATA_W-1:0]          dout,
  output logic                            valid,
  output logic      [$clog2(DEPTH):0]     count,
  output logic                            full
);
  localparam int                  c_ptr_w = $clog2(DEPTH);
  localparam int                  c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0]  c_depth = c_cnt_w'(DEPTH);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_do_pop;
  logic               w_do_push;

  assign valid     = (r_count != '0);
  assign full      = (r_count == c_depth);
  assign count     = r_count;
  assign dout      = valid ? r_mem[r_rd_ptr] : '0;
  assign w_do_pop  = pop && valid;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/conv1x1_accum_requant.sv
`default_nettype none
// ============================================================================
// Module   : conv1x1_accum_requant
// Brief    : Sums CIN MAC beats per pixel, requantizes, and queues results for writeback.
// Revision : 1.0
// ============================================================================
module conv1x1_accum_requant
  import conv_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int IN_W       = 2 * WIDTH,
  parameter int CIN        = 8,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int SHIFT      = 8,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int RELU       = 1,
  parameter int FIFO_DEPTH = 4
) (
  input wire logic                  clk,
  input wire logic                  rst_n,
  conv1x1_accum_requant_if.slave    bus
);
  localparam int                    c_cnt_w  = $clog2(CIN);
  localparam logic [c_cnt_w-1:0]    c_last   = c_cnt_w'(CIN - 1);
  localparam int                    c_fcnt_w = $clog2(FIFO_DEPTH) + 1;
  localparam logic [c_fcnt_w-1:0]   c_af_lvl = c_fcnt_w'(FIFO_DEPTH - 1);

  logic [c_cnt_w-1:0]      r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_sum_valid;
  logic [OUT_W-1:0]        r_q;
  logic                    r_q_valid;
  logic                    r_overflow;

  logic signed [ACC_W-1:0] w_y_ext;
  acc_t                    w_req;
  logic                    w_pop;
  logic                    w_full;
  logic [c_fcnt_w-1:0]     w_count;

  assign w_y_ext = {{(ACC_W - IN_W){bus.y_in[IN_W-1]}}, bus.y_in};
  assign w_req   = round_shift_sat(acc_t'(r_acc), SHIFT, (RELU != 0), OUT_W);
  assign w_pop   = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_sum_valid <= 1'b0;
    end else begin
      r_sum_valid <= 1'b0;
      if (bus.valid_in) begin
        r_acc <= (r_cnt == '0) ? w_y_ext : (r_acc + w_y_ext);
        if (r_cnt == c_last) begin
          r_cnt       <= '0;
          r_sum_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // The MAC stage cannot be stalled, so a push into a full FIFO with no
  // simultaneous pop is lost and latched as a sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q        <= '0;
      r_q_valid  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_q_valid <= r_sum_valid;
      if (r_sum_valid) r_q <= w_req[OUT_W-1:0];
      if (r_q_valid && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  conv_out_fifo #(
    .DATA_W (OUT_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_q_valid),
    .din   (r_q),
    .pop   (w_pop),
    .dout  (bus.out_data),
    .valid (bus.out_valid),
    .count (w_count),
    .full  (w_full)
  );

  assign bus.almost_full = (w_count >= c_af_lvl);
  assign bus.overflow    = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_conv1x1_accum_requant.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv1x1_accum_requant
// Brief    : Directed bench; two DUTs (RELU=1 as A, RELU=0 as B) share one stimulus stream.
// Revision : 1.0
// ============================================================================
module tb_conv1x1_accum_requant;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] y_in = '0;
  logic        out_ready = 1'b1;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  conv1x1_accum_requant_if #(.IN_W(32), .OUT_W(16)) ifa ();
  conv1x1_accum_requant_if #(.IN_W(32), .OUT_W(16)) ifb ();

  assign ifa.valid_in  = valid_in;
  assign ifa.y_in      = y_in;
  assign ifa.out_ready = out_ready;
  assign ifb.valid_in  = valid_in;
  assign ifb.y_in      = y_in;
  assign ifb.out_ready = out_ready;

  conv1x1_accum_requant #(.CIN(4), .SHIFT(8), .RELU(1), .FIFO_DEPTH(4)) u_dut_a (
    .clk (clk), .rst_n (rst_n), .bus (ifa.slave));
  conv1x1_accum_requant #(.CIN(4), .SHIFT(8), .RELU(0), .FIFO_DEPTH(4)) u_dut_b (
    .clk (clk), .rst_n (rst_n), .bus (ifb.slave));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [31:0] v);
    @(negedge clk);
    valid_in = 1'b1;
    y_in     = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
  endtask

  task automatic send_pixel(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d);
    beat(a); beat(b); beat(c); beat(d);
  endtask

  task automatic wait_head(input string tag, input logic [15:0] exp_a, input logic [15:0] exp_b);
    int n = 0;
    do begin
      @(negedge clk);
      valid_in = 1'b0;
      n++;
    end while (!(ifa.out_valid && ifb.out_valid) && n < 12);
    check_eq({tag, "_valid"}, 32'(ifa.out_valid & ifb.out_valid), 32'd1);
    check_eq({tag, "_a"}, 32'(ifa.out_data), 32'(exp_a));
    check_eq({tag, "_b"}, 32'(ifb.out_data), 32'(exp_b));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    valid_in = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int seen;
    idle(2);
    check_eq("rst_valid", 32'(ifa.out_valid), 32'd0);
    check_eq("rst_data", 32'(ifa.out_data), 32'd0);
    check_eq("rst_af", 32'(ifa.almost_full), 32'd0);
    check_eq("rst_ovf", 32'(ifa.overflow), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Latency: out_valid visible only after the third edge following the last beat
    send_pixel(256, 512, 768, 1024);
    idle(1); check_eq("lat_e0", 32'(ifa.out_valid), 32'd0);
    idle(1); check_eq("lat_e1", 32'(ifa.out_valid), 32'd0);
    idle(1); check_eq("lat_e2", 32'(ifa.out_valid), 32'd1);
    check_eq("lat_data", 32'(ifa.out_data), 32'd10);
    idle(3);

    send_pixel(96, 96, 96, 96);           wait_head("round_up", 16'd2, 16'd2);
    send_pixel(95, 95, 95, 98);           wait_head("round_dn", 16'd1, 16'd1);
    send_pixel(-32'sd1000, -32'sd1000, -32'sd1000, -32'sd1000);
    wait_head("neg", 16'd0, 16'hFFF0);
    send_pixel(32'h00FFFFFF, 32'h00FFFFFF, 32'h00FFFFFF, 32'h00FFFFFF);
    wait_head("sat_hi", 16'h7FFF, 16'h7FFF);
    send_pixel(32'hFF000000, 32'hFF000000, 32'hFF000000, 32'hFF000000);
    wait_head("sat_lo", 16'h0000, 16'h8000);
    idle(2);

    // Backpressure: five results into a four-entry FIFO
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send_pixel(32'(256 * (k + 1)), 0, 0, 0);
      idle(4);
      if (k == 1) check_eq("bp_af_cnt2", 32'(ifa.almost_full), 32'd0);
      if (k == 2) check_eq("bp_af_cnt3", 32'(ifa.almost_full), 32'd1);
      if (k == 3) check_eq("bp_ovf_cnt4", 32'(ifa.overflow), 32'd0);
    end
    check_eq("bp_ovf", 32'(ifa.overflow), 32'd1);
    check_eq("bp_ovf_b", 32'(ifb.overflow), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check_eq($sformatf("bp_drain%0d_v", i), 32'(ifa.out_valid), 32'd1);
      check_eq($sformatf("bp_drain%0d_d", i), 32'(ifa.out_data), 32'(i + 1));
    end
    @(negedge clk);
    check_eq("bp_empty_v", 32'(ifa.out_valid), 32'd0);
    check_eq("bp_empty_d", 32'(ifa.out_data), 32'd0);

    // Push and pop on the same edge while full
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send_pixel(32'(256 * (k + 1)), 0, 0, 0);
      idle(4);
    end
    send_pixel(32'(256 * 5), 0, 0, 0);
    idle(1);                  // after E0
    idle(1);                  // after E1: q_valid high, push lands on E2
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check_eq("pp_ovf", 32'(ifa.overflow), 32'd0);
    check_eq("pp_af", 32'(ifa.almost_full), 32'd1);
    idle(1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check_eq($sformatf("pp_drain%0d", i), 32'(ifa.out_data), 32'(i + 2));
    end
    @(negedge clk);
    check_eq("pp_empty", 32'(ifa.out_valid), 32'd0);

    // Reset mid-accumulation discards the partial sum
    beat(5000); beat(5000);
    @(negedge clk);
    valid_in = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_eq("mid_rst_v", 32'(ifa.out_valid | ifb.out_valid), 32'd0);
    check_eq("mid_rst_d", 32'(ifa.out_data | ifb.out_data), 32'd0);
    check_eq("mid_rst_flags", 32'({ifa.almost_full, ifa.overflow}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_pixel(256, 256, 256, 256);
    wait_head("mid_rst_out", 16'd4, 16'd4);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ifa.out_valid) seen++;
    end
    check_eq("mid_rst_single", 32'(seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/conv1x1_accum_requant.md
Name: conv1x1_accum_requant

Overview:
Downstream neighbour of the 1x1 conv MAC stage. It accumulates CIN consecutive per-channel MAC results into one output-pixel sum, then requantizes it with round, arithmetic shift, optional ReLU and saturation. Results go into a small output FIFO with a ready/valid interface to the writeback stage. The MAC stage cannot stall, so this block exports an almost_full hint to the upstream scheduler and flags dropped results.

Parameters:
WIDTH, 16, operand width of the MAC stage
IN_W, 2*WIDTH, width of incoming MAC result (two's complement)
CIN, 8, input channels summed per output pixel (>=2)
ACC_W, 40, accumulator width (>= IN_W + clog2(CIN))
SHIFT, 8, requant right-shift (>=1)
OUT_W, 16, output width (signed)
RELU, 1, 1 = clamp negatives to 0
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  MAC result beat valid
y_in  in  IN_W  MAC result, signed
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_data  out  OUT_W  requantized pixel, signed
almost_full  out  1  FIFO count >= FIFO_DEPTH-1
overflow  out  1  sticky: a result was dropped

Behaviour:
- Reset (async assert, sync release): beat counter=0, acc=0, sum_valid=0, q_valid=0, FIFO empty, out_valid=0, out_data=0, almost_full=0, overflow=0.
- Reset mid-accumulation discards the partial sum. The next valid beat is channel 0.
- Accumulate, on each valid_in edge:
  - cnt==0: acc <= sext(y_in).
  - otherwise: acc <= acc + sext(y_in).
  - cnt wraps at CIN-1 to 0. On the wrap beat, sum_valid is set for one cycle.
- Cycles with valid_in=0 hold cnt and acc. Gaps between beats are allowed.
- Requant stage, registered, when sum_valid:
  - r = (acc + 2^(SHIFT-1)) >>> SHIFT, arithmetic, i.e. round half up.
  - If RELU and r<0, r=0.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - q <= r; q_valid pulses.
- FIFO push on q_valid, pop on out_valid && out_ready.
- Latency: last beat sampled at edge E0, q at E1, FIFO write at E2. With FIFO empty, out_valid rises after E2.
- out_data = head entry while out_valid, 0 when empty. Held stable while out_valid && !out_ready.
- Full with push and pop in the same cycle: both happen, count unchanged, no overflow.
- Full with push and no pop: result dropped, overflow <= 1. It stays 1 until reset.
- Empty: pop ignored, out_valid=0.
- Order is strictly FIFO. Pointers wrap modulo FIFO_DEPTH. Count is tracked separately so full and empty are unambiguous.
- almost_full is combinational from count.

Decomposition:
- Shared package conv_pkg:
  - width constants (WIDTH, ACC_W, OUT_W defaults);
  - signed accumulator and output typedefs;
  - function round_shift_sat(acc, shift, relu) used by the requant stage.
- One sub-module: conv_out_fifo, a synchronous FIFO.
  - Parameters DATA_W and DEPTH.
  - Ports: push, din, pop, dout, valid, count, full.

Test Plan:
1. CIN=4, SHIFT=8; beats 256,512,768,1024 -> out_data=10, out_valid asserted 3 edges after the last beat.
2. Rounding: 4 beats of 96 (sum 384) -> 2. 4 beats of 95 plus 3 (sum 383) -> 1.
3. Negative: 4 beats of -1000 (sum -4000) -> RELU=1 gives 0. RELU=0 gives -16 (0xFFF0).
4. Saturation: 4 beats of 0x00FFFFFF -> 32767. RELU=0 with 4 beats of 0xFF000000 -> -32768.
5. Backpressure: out_ready=0 while 5 results are produced, FIFO_DEPTH=4.
   - almost_full=1 once count=3; overflow=1 after the 5th result.
   - Then out_ready=1: the first 4 results drain in order, then out_valid=0.
   - Also check push and pop in the same cycle while full: no overflow.
6. Reset mid-op: 2 beats of 5000, pulse rst_n low for 1 cycle, then 4 beats of 256.
   - Single output of 4. Partial sum discarded; all outputs are 0 during reset.
